// File: rtl/sprite_draw_sequencer_pkg.sv
// rtl/sprite_draw_sequencer_pkg.sv - shared constants, widths and state encoding for the sprite draw sequencer
package sprite_draw_sequencer_pkg;

    localparam int FB_WIDTH   = 320;
    localparam int FB_HEIGHT  = 240;
    localparam int SPRITE_DIM = 8;

    localparam int COORD_W = 17;
    localparam int IMG_W   = 8;

    // Last top-left address at which a whole 8x8 sprite still fits in the frame
    localparam logic [COORD_W-1:0] DEFAULT_MAX_COORD =
        COORD_W'((FB_HEIGHT - SPRITE_DIM) * FB_WIDTH + (FB_WIDTH - SPRITE_DIM));

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_ARM   = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        ISSUE = ST_ISSUE,
        ARM   = ST_ARM,
        WAIT  = ST_WAIT,
        FIN   = ST_FIN
    } state_t;

endpackage

// File: rtl/sprite_draw_sequencer_if.sv
// rtl/sprite_draw_sequencer_if.sv - start/coord/img_sel/done handshake between sequencer and sprite drawer
interface sprite_draw_sequencer_if;
    import sprite_draw_sequencer_pkg::*;

    logic               draw_start;
    logic [COORD_W-1:0] draw_coord;
    logic [IMG_W-1:0]   draw_img;
    logic               draw_done;

    modport master (output draw_start, draw_coord, draw_img, input draw_done);
    modport slave  (input draw_start, draw_coord, draw_img, output draw_done);

endinterface

// File: rtl/sprite_draw_sequencer_sprite_table.sv
// rtl/sprite_draw_sequencer_sprite_table.sv - register-based sprite table with one write port and a registered read
module sprite_table
    import sprite_draw_sequencer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [COORD_W-1:0]       wr_coord,
    input  logic [IMG_W-1:0]         wr_img,
    input  logic                     wr_valid,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     rd_valid,
    output logic [COORD_W-1:0]       rd_coord,
    output logic [IMG_W-1:0]         rd_img
);

    logic [DEPTH-1:0]   valid_q;
    logic [COORD_W-1:0] coord_q [DEPTH];
    logic [IMG_W-1:0]   img_q   [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_addr] <= wr_valid;
        end
    end

    // Payload is meaningless while the valid bit is clear, so it carries no reset
    always_ff @(posedge clk) begin
        if (we) begin
            coord_q[wr_addr] <= wr_coord;
            img_q[wr_addr]   <= wr_img;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_coord <= '0;
            rd_img   <= '0;
        end else if (rd_en) begin
            rd_valid <= valid_q[rd_addr];
            rd_coord <= coord_q[rd_addr];
            rd_img   <= img_q[rd_addr];
        end
    end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// rtl/sprite_draw_sequencer.sv - walks the sprite table once per frame, issuing one drawer command per enabled entry
// Optional off-screen clipping and skip counter: define SPRITE_SEQ_CLIP_EN.
module sprite_draw_sequencer
    import sprite_draw_sequencer_pkg::*;
#(
    parameter int NUM_SPRITES = 16
`ifdef SPRITE_SEQ_CLIP_EN
   ,parameter logic [COORD_W-1:0] MAX_COORD = DEFAULT_MAX_COORD
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic                           tbl_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] tbl_addr,
    input  logic [COORD_W-1:0]             tbl_coord,
    input  logic [IMG_W-1:0]               tbl_img,
    input  logic                           tbl_valid,
    sprite_draw_sequencer_if.master        draw,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           frame_overrun
`ifdef SPRITE_SEQ_CLIP_EN
   ,output logic [7:0]                     skip_count
`endif
);

    localparam int IDX_W = $clog2(NUM_SPRITES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               fetch, clipped, draw_ok, last;
    logic               hold_valid;
    logic [COORD_W-1:0] hold_coord;
    logic [IMG_W-1:0]   hold_img;
    logic               start_q, start_n;
    logic [COORD_W-1:0] coord_q, coord_n;
    logic [IMG_W-1:0]   img_q, img_n;
    logic               busy_n, done_n, overrun_n;

    sprite_table #(.DEPTH(NUM_SPRITES)) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (tbl_we),
        .wr_addr  (tbl_addr),
        .wr_coord (tbl_coord),
        .wr_img   (tbl_img),
        .wr_valid (tbl_valid),
        .rd_en    (fetch),
        .rd_addr  (idx),
        .rd_valid (hold_valid),
        .rd_coord (hold_coord),
        .rd_img   (hold_img)
    );

`ifdef SPRITE_SEQ_CLIP_EN
    logic [7:0] skip_q;

    assign clipped = hold_valid && (hold_coord > MAX_COORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_q <= '0;
        end else if (state == IDLE && frame_start) begin
            skip_q <= '0;
        end else if (state == ISSUE && clipped && skip_q != 8'hFF) begin
            skip_q <= skip_q + 8'd1;
        end
    end

    assign skip_count = skip_q;
`else
    assign clipped = 1'b0;
`endif

    assign draw_ok = hold_valid && !clipped;
    assign last    = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            start_q       <= 1'b0;
            coord_q       <= '0;
            img_q         <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            start_q       <= start_n;
            coord_q       <= coord_n;
            img_q         <= img_n;
            busy          <= busy_n;
            frame_done    <= done_n;
            frame_overrun <= overrun_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        fetch     = 1'b0;
        start_n   = 1'b0;
        coord_n   = coord_q;
        img_n     = img_q;
        overrun_n = frame_start && (state != IDLE);
        case (state)
            IDLE: begin
                if (frame_start) begin
                    idx_n   = '0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                fetch   = 1'b1;
                state_n = ISSUE;
            end
            ISSUE: begin
                if (draw_ok) begin
                    start_n = 1'b1;
                    coord_n = hold_coord;
                    img_n   = hold_img;
                    state_n = ARM;
                end else if (last) begin
                    state_n = FIN;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = FETCH;
                end
            end
            // The drawer's done from the previous sprite is still high here
            ARM: state_n = WAIT;
            WAIT: begin
                if (draw.draw_done) begin
                    if (last) begin
                        state_n = FIN;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE) && (state_n != FIN);
        done_n = (state_n == FIN);
    end

    assign draw.draw_start = start_q;
    assign draw.draw_coord = coord_q;
    assign draw.draw_img   = img_q;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// tb/tb_sprite_draw_sequencer.sv - directed table-driven bench for sprite_draw_sequencer with a drawer model
`timescale 1ns/1ps
module tb_sprite_draw_sequencer;
    import sprite_draw_sequencer_pkg::*;

    typedef struct {
        int unsigned        addr;
        logic [COORD_W-1:0] coord;
        logic [IMG_W-1:0]   img;
        logic               valid;
        int                 exp_off;   // cycles from frame_start to draw_start, -1 when never drawn
    } vec_t;

    typedef struct {
        int                 off;
        logic [COORD_W-1:0] coord;
        logic [IMG_W-1:0]   img;
    } draw_t;

    logic               clk;
    logic               rst_n;
    logic               frame_start;
    logic               tbl_we;
    logic [3:0]         tbl_addr;
    logic [COORD_W-1:0] tbl_coord;
    logic [IMG_W-1:0]   tbl_img;
    logic               tbl_valid;
    logic               busy, frame_done, frame_overrun;
`ifdef SPRITE_SEQ_CLIP_EN
    logic [7:0]         skip_count;
`endif

    sprite_draw_sequencer_if bus();

    sprite_draw_sequencer #(.NUM_SPRITES(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .tbl_we        (tbl_we),
        .tbl_addr      (tbl_addr),
        .tbl_coord     (tbl_coord),
        .tbl_img       (tbl_img),
        .tbl_valid     (tbl_valid),
        .draw          (bus),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_overrun (frame_overrun)
`ifdef SPRITE_SEQ_CLIP_EN
       ,.skip_count    (skip_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drawer: done is sticky, drops the cycle after start and rises lat cycles later
    logic        done_r;
    int unsigned dcnt;
    int unsigned lat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
            dcnt   <= 0;
        end else if (bus.draw_start) begin
            done_r <= 1'b0;
            dcnt   <= lat;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) done_r <= 1'b1;
        end
    end
    assign bus.draw_done = done_r;

    int                 checks, errors, cyc, fs_cyc, done_off, busy_cnt, ovr_cnt;
    draw_t              st_q[$];
    logic [COORD_W-1:0] prev_coord;
    logic [IMG_W-1:0]   prev_img;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        draw_t d;
        @(negedge clk);
        cyc++;
        if (bus.draw_start) begin
            chk("single_outstanding", dcnt, 0);
            d.off   = cyc - fs_cyc;
            d.coord = bus.draw_coord;
            d.img   = bus.draw_img;
            st_q.push_back(d);
        end else begin
            chk("draw_args_stable", {7'd0, bus.draw_img, bus.draw_coord}, {7'd0, prev_img, prev_coord});
        end
        prev_coord = bus.draw_coord;
        prev_img   = bus.draw_img;
        if (busy) busy_cnt++;
        if (frame_overrun) ovr_cnt++;
        if (frame_done && done_off < 0) done_off = cyc - fs_cyc;
    endtask

    task automatic check_idle_outputs();
        chk("rst_draw_start", bus.draw_start, 0);
        chk("rst_draw_coord", bus.draw_coord, 0);
        chk("rst_draw_img", bus.draw_img, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_overrun", frame_overrun, 0);
`ifdef SPRITE_SEQ_CLIP_EN
        chk("rst_skip_count", skip_count, 0);
`endif
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        prev_coord = '0;
        prev_img   = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wr(input int unsigned a, input logic [COORD_W-1:0] c, input logic [IMG_W-1:0] im, input logic v);
        tbl_we    = 1'b1;
        tbl_addr  = 4'(a);
        tbl_coord = c;
        tbl_img   = im;
        tbl_valid = v;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic pulse_frame();
        st_q.delete();
        busy_cnt    = 0;
        ovr_cnt     = 0;
        done_off    = -1;
        frame_start = 1'b1;
        fs_cyc      = cyc;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done_off < 0; i++) tick();
        chk("frame_done_seen", (done_off >= 0), 1);
        tick();
        tick();
    endtask

    task automatic wait_start(input int bound);
        for (int i = 0; i < bound && !bus.draw_start; i++) tick();
        chk("draw_start_seen", bus.draw_start, 1);
    endtask

    vec_t  v[3];
    draw_t e4[3];
    int    exp_n;

    initial begin
        checks = 0; errors = 0; cyc = 0; fs_cyc = 0; done_off = -1; busy_cnt = 0; ovr_cnt = 0;
        rst_n = 1'b0; frame_start = 1'b0; tbl_we = 1'b0; tbl_addr = '0;
        tbl_coord = '0; tbl_img = '0; tbl_valid = 1'b0; lat = 70;
        prev_coord = '0; prev_img = '0;

        v[0] = '{0,  17'd0,     8'h01, 1'b1, 3};
        v[1] = '{7,  17'd5000,  8'h77, 1'b0, -1};
        v[2] = '{15, 17'd74552, 8'h2A, 1'b1, 105};
        e4[0] = '{9,  17'd100, 8'd3};
        e4[1] = '{23, 17'd200, 8'd4};
        e4[2] = '{45, 17'd900, 8'd9};

        tick();
        tick();
        check_idle_outputs();
        rst_n = 1'b1;
        tick();

        // Empty table: 2*16+1 cycles, no draws
        pulse_frame();
        wait_done(100);
        chk("empty_draws", st_q.size(), 0);
        chk("empty_done_off", done_off, 33);
        chk("empty_busy_cycles", busy_cnt, 32);
        chk("empty_overrun", ovr_cnt, 0);

        // Table-driven walk: entries 0 and 15 drawn, entry 7 disabled
        for (int i = 0; i < 3; i++) wr(v[i].addr, v[i].coord, v[i].img, v[i].valid);
        pulse_frame();
        wait_done(400);
        exp_n = 0;
        for (int i = 0; i < 3; i++) begin
            if (v[i].exp_off >= 0) begin
                if (exp_n < st_q.size()) begin
                    chk("walk_draw_off", st_q[exp_n].off, v[i].exp_off);
                    chk("walk_draw_coord", st_q[exp_n].coord, v[i].coord);
                    chk("walk_draw_img", st_q[exp_n].img, v[i].img);
                end else begin
                    chk("walk_draw_count_at", st_q.size(), exp_n + 1);
                end
                exp_n++;
            end
        end
        chk("walk_draw_count", st_q.size(), exp_n);
        chk("walk_done_off", done_off, 177);
        chk("walk_busy_cycles", busy_cnt, 176);

        // Adjacent draws with stale done, mid-walk write to entry 9 and a dropped frame_start
        lat = 10;
        reset_dut();
        wr(3, 17'd100, 8'd3, 1'b1);
        wr(4, 17'd200, 8'd4, 1'b1);
        pulse_frame();
        wait_start(40);
        tbl_we = 1'b1; tbl_addr = 4'd9; tbl_coord = 17'd900; tbl_img = 8'd9; tbl_valid = 1'b1;
        frame_start = 1'b1;
        tick();
        tbl_we = 1'b0;
        frame_start = 1'b0;
        wait_done(300);
        chk("mid_draw_count", st_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < st_q.size()) begin
                chk("mid_draw_off", st_q[i].off, e4[i].off);
                chk("mid_draw_coord", st_q[i].coord, e4[i].coord);
                chk("mid_draw_img", st_q[i].img, e4[i].img);
            end
        end
        chk("mid_done_off", done_off, 69);
        chk("mid_busy_cycles", busy_cnt, 68);
        chk("mid_overrun_pulses", ovr_cnt, 1);

        // Entry one past the last on-screen address
        reset_dut();
        wr(5, 17'd74553, 8'h55, 1'b1);
        pulse_frame();
        wait_done(200);
`ifdef SPRITE_SEQ_CLIP_EN
        chk("clip_draws", st_q.size(), 0);
        chk("clip_skip_count", skip_count, 1);
        chk("clip_done_off", done_off, 33);
`else
        chk("noclip_draws", st_q.size(), 1);
        if (st_q.size() > 0) begin
            chk("noclip_draw_off", st_q[0].off, 13);
            chk("noclip_draw_coord", st_q[0].coord, 17'd74553);
            chk("noclip_draw_img", st_q[0].img, 8'h55);
        end
        chk("noclip_done_off", done_off, 45);
`endif

        // Asynchronous reset while waiting on the drawer
        lat = 70;
        reset_dut();
        wr(2, 17'd3210, 8'hC3, 1'b1);
        pulse_frame();
        wait_start(40);
        for (int i = 0; i < 5; i++) tick();
        chk("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs();
        prev_coord = '0;
        prev_img   = '0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_frame();
        wait_done(100);
        chk("post_reset_draws", st_q.size(), 0);
        chk("post_reset_done_off", done_off, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_draw_sequencer.md
# sprite_draw_sequencer

Walks a table of up to NUM_SPRITES sprite entries once per frame and issues one draw command per enabled entry to the downstream sprite drawer (8x8, 64-pixel sprites written into the 320x240 frame buffer). It sits between game/move logic, which writes the table, and the sprite drawer, which it drives through the start/coordinates/img_sel/done handshake. It serialises all sprite draws so the drawer never receives a start while a sprite is in flight.

## Interface
- NUM_SPRITES, 16: table depth; must be a power of two, 2..256.
- MAX_COORD, 17'd74552: largest legal top-left linear address (row 232 × 320 + column 312); used only with the clip feature.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- frame_start  in  1  one-cycle pulse requesting a table walk.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  $clog2(NUM_SPRITES)  entry index for the write.
- tbl_coord  in  17  top-left linear frame address (row × 320 + column).
- tbl_img  in  8  sprite image select.
- tbl_valid  in  1  entry enable.
- draw_start  out  1  one-cycle start pulse to the drawer.
- draw_coord  out  17  coordinates to the drawer.
- draw_img  out  8  img_sel to the drawer.
- draw_done  in  1  drawer done. It is sticky and clears the cycle after start.
- busy  out  1  high while a walk is in progress.
- frame_done  out  1  one-cycle pulse when a walk completes.
- frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy.
- skip_count  out  8  present only with SPRITE_SEQ_CLIP_EN.

## Operation
- Table storage: NUM_SPRITES × {valid, coord[16:0], img[7:0]} in registers. Reset clears every valid bit; coord and img are don't-care after reset.
- Table writes are accepted in every cycle, including during a walk.
  - A write to an entry not yet fetched in the current walk takes effect in that walk.
  - A write to an entry already fetched takes effect in the next walk.
  - A write in the same cycle as the FETCH of that entry: FETCH sees the old value.
- States: IDLE, FETCH, ISSUE, ARM, WAIT, FIN.
- IDLE: on frame_start, clear idx to 0 and go to FETCH.
- FETCH: latch entry[idx] into the holding registers, then go to ISSUE.
- ISSUE:
  - If the held entry is valid, assert draw_start, load draw_coord/draw_img from the holding registers, and go to ARM.
  - Otherwise, skip the entry: if idx == NUM_SPRITES-1 go to FIN; else increment idx and go to FETCH.
- ARM: ignore draw_done for exactly one cycle (the drawer's stale done is still high), then go to WAIT.
- WAIT: when draw_done == 1, go to FIN if idx == NUM_SPRITES-1; otherwise increment idx and go to FETCH.
- FIN: pulse frame_done, then go to IDLE.
- idx never wraps within a walk; the walk ends strictly after the last entry.
- frame_start in any state other than IDLE is dropped and pulses frame_overrun in the following cycle.
- An asynchronous reset mid-walk returns the block to IDLE, clears the table valid bits, and deasserts all outputs. The drawer is reset by the same rst_n.

## Timing
- Reset values: draw_start=0, draw_coord=0, draw_img=0, busy=0, frame_done=0, frame_overrun=0, skip_count=0.
- All outputs are registered.
- draw_coord and draw_img change only in the cycle draw_start is asserted, and stay stable until the next draw_start.
- busy rises the cycle after frame_start and falls in the same cycle frame_done pulses.
- Cost per entry:
  - Skipped entry: 2 cycles (FETCH, ISSUE).
  - Drawn entry: 3 cycles plus the drawer latency (FETCH, ISSUE, ARM, then WAIT until done).
- An empty table completes in 2·NUM_SPRITES + 1 cycles from the cycle after frame_start through the frame_done pulse.
- There is never more than one outstanding draw_start.

## Configuration
- SPRITE_SEQ_CLIP_EN defined:
  - In ISSUE, a valid entry with coord > MAX_COORD is treated as invalid and not drawn.
  - skip_count increments (saturating at 255) for each such entry.
  - skip_count clears on each accepted frame_start.
- SPRITE_SEQ_CLIP_EN undefined: every valid entry is drawn, and the skip_count port is absent.

## Structure
- Shared package holds:
  - state encoding localparams.
  - FB_WIDTH=320, FB_HEIGHT=240, SPRITE_DIM=8.
  - coordinate width 17 and image-select width 8.
  - default MAX_COORD.
- One sub-module, sprite_table: register array, write port, synchronous read of one entry.

## Test plan
- Reset, then frame_start with an empty table: no draw_start; frame_done exactly 33 cycles after frame_start for NUM_SPRITES=16; busy high for the interval in between.
- Entries 0 and 15 valid (coord 17'd0, img 8'h01; coord 17'd74552, img 8'h2A), drawer model with a 70-cycle done: exactly two draw_start pulses, with matching coord/img, in index order; no second start before done.
- Stale draw_done held high from the previous sprite: no idx advance in ARM; advance only on done in WAIT.
- frame_start reasserted mid-walk: frame_overrun pulses once and the walk continues unaffected. A tbl_we to entry 9 while idx=3 is drawn in the same walk.
- With SPRITE_SEQ_CLIP_EN, entry coord 17'd74553: not drawn, skip_count=1. Without the macro, the same entry is drawn.
- rst_n asserted during WAIT: outputs go to 0 immediately, and a later frame_start walks a cleared table.
